// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and request record for the data-memory
// arbiter.
//   MEM_DEPTH  - data memory depth in 32-bit words
//   WORD_BYTES - bytes per memory word
//   NUM_PORTS  - requesters sharing the memory (0 = LSU, 1 = loader/debug)
//   mem_req_t  - one requester's request channel bundled as a record
package mem_arbiter_pkg;

  localparam int MEM_DEPTH  = 1024;
  localparam int WORD_BYTES = 4;
  localparam int NUM_PORTS  = 2;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_addr_check.sv
// mem_addr_check: effective-address computation and legality check for one
// requester.
//   base, offset - signed byte address operands
//   err          - 1 when the effective address is misaligned, negative or
//                  past the last word of the memory
module mem_addr_check
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic [31:0] base,
  input  logic [31:0] offset,
  output logic        err
);

  logic [31:0] ea;
  logic [31:0] widx;

  // 32-bit two's complement add; wrap-around is intentional
  assign ea   = base + offset;
  // ea[31] set means a negative address, so only the non-negative case
  // needs the word-index bound
  assign widx = {2'b00, ea[31:2]};
  assign err  = (ea[1:0] != 2'b00) | ea[31] | (widx >= 32'(DEPTH));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the single-port 1024x32 data memory
// between the load/store unit (port 0) and the loader/debug port (port 1).
//   clk, rst            - clock, async active-high reset
//   reqN_valid/ready    - request handshake, port N
//   reqN_we/base/offset/wdata - request payload (byte addressing, signed)
//   rspN_valid/rdata/err - one-cycle response, one cycle after accept
//   mem_*               - drive to the synchronous memory; mem_r_data is
//                          valid the cycle after mem_r_enabled
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH     = MEM_DEPTH,
  parameter int PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_base,
  input  logic [31:0] req0_offset,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_base,
  input  logic [31:0] req1_offset,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_base,
  output logic [31:0] mem_offset,
  output logic        mem_r_enabled,
  output logic        mem_w_enabled,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam logic PRIO_RST = (PRIO_INIT != 0);

  mem_req_t [NUM_PORTS-1:0] req;
  logic     [NUM_PORTS-1:0] err;
  logic     [NUM_PORTS-1:0] gnt;
  logic     [NUM_PORTS-1:0] accept;
  logic                     prio;
  logic                     win;
  logic                     issue;
  logic                     contend;

  // registered response state, one slot per port
  logic     [NUM_PORTS-1:0] pend_vld;
  logic     [NUM_PORTS-1:0] pend_err;
  logic     [NUM_PORTS-1:0] pend_rd;

  assign req[0] = '{valid: req0_valid, we: req0_we, base: req0_base,
                    offset: req0_offset, wdata: req0_wdata};
  assign req[1] = '{valid: req1_valid, we: req1_we, base: req1_base,
                    offset: req1_offset, wdata: req1_wdata};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chk
    mem_addr_check #(.DEPTH(DEPTH)) u_chk (
      .base  (req[p].base),
      .offset(req[p].offset),
      .err   (err[p])
    );
  end

  // ---- grant ----
  assign contend = req[0].valid & req[1].valid;

  always_comb begin
    gnt = '0;
    if (contend)           gnt[prio] = 1'b1;
    else if (req[0].valid) gnt[0]    = 1'b1;
    else if (req[1].valid) gnt[1]    = 1'b1;
  end

  // nothing is accepted while reset is held, so no strobe can leak out
  assign accept = gnt & {NUM_PORTS{~rst}};
  assign win    = gnt[1];
  assign issue  = (|accept) & ~err[win];

  assign req0_ready = accept[0];
  assign req1_ready = accept[1];

  // ---- memory drive: quiet (all zero) unless a legal access issues ----
  assign mem_base      = issue ? req[win].base   : 32'h0;
  assign mem_offset    = issue ? req[win].offset : 32'h0;
  assign mem_w_data    = issue ? req[win].wdata  : 32'h0;
  assign mem_r_enabled = issue & ~req[win].we;
  assign mem_w_enabled = issue &  req[win].we;

  // ---- priority: a contended accept hands priority to the loser ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prio <= PRIO_RST;
    else if (contend) prio <= ~win;
  end

  // ---- response pipeline ----
  // Error and write accesses still occupy the slot; only a legal read
  // lets memory data through on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= '0;
      pend_err <= '0;
      pend_rd  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        pend_vld[p] <= accept[p];
        pend_err[p] <= accept[p] & err[p];
        pend_rd[p]  <= accept[p] & ~err[p] & ~req[p].we;
      end
    end
  end

  assign rsp0_valid = pend_vld[0];
  assign rsp0_err   = pend_err[0];
  assign rsp0_rdata = pend_rd[0] ? mem_r_data : 32'h0;
  assign rsp1_valid = pend_vld[1];
  assign rsp1_err   = pend_err[1];
  assign rsp1_rdata = pend_rd[1] ? mem_r_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven check of mem_arbiter against a
// behavioural synchronous 1024x32 memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_base, req0_offset, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_base, req1_offset, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic [31:0] mem_base, mem_offset, mem_w_data, mem_r_data;
  logic        mem_r_enabled, mem_w_enabled;
  logic        preload;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(1024), .PRIO_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_base(req0_base), .req0_offset(req0_offset), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_base(req1_base), .req1_offset(req1_offset), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_base(mem_base), .mem_offset(mem_offset),
    .mem_r_enabled(mem_r_enabled), .mem_w_enabled(mem_w_enabled),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // behavioural memory: word index from base+offset, 1-cycle read latency
  logic [31:0] mem [0:1023];
  logic [31:0] m_ea;
  assign m_ea = mem_base + mem_offset;

  always @(posedge clk) begin
    if (preload) begin
      mem[10'h040] <= 32'hCAFEF00D;
      mem[10'h041] <= 32'hDEADBEEF;
    end else if (mem_w_enabled) begin
      mem[m_ea[11:2]] <= mem_w_data;
    end
    if (mem_r_enabled) mem_r_data <= mem[m_ea[11:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'h0, act}, {31'h0, exp});
  endtask

  typedef struct {
    bit v0; bit we0; bit [31:0] b0; bit [31:0] o0; bit [31:0] d0;
    bit v1; bit we1; bit [31:0] b1; bit [31:0] o1; bit [31:0] d1;
    bit rdy0; bit rdy1; bit ren; bit wen;
    bit [31:0] mb; bit [31:0] mo; bit [31:0] mwd;
    bit rv0; bit re0; bit [31:0] rd0;
    bit rv1; bit re1; bit [31:0] rd1;
  } vec_t;

  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;
  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    // fields: port0 req | port1 req | rdy0 rdy1 ren wen mbase moff mwdata | rsp0 v/err/rdata | rsp1 v/err/rdata
    // idle
    vecs[0]  = '{N,N,32'h0,32'h0,32'h0, N,N,32'h0,32'h0,32'h0, N,N,N,N,32'h0,32'h0,32'h0, N,N,32'h0, N,N,32'h0};
    // single read, ea 0x104 = word 0x41
    vecs[1]  = '{Y,N,32'h100,32'h4,32'h0, N,N,32'h0,32'h0,32'h0, Y,N,Y,N,32'h100,32'h4,32'h0, Y,N,32'hDEADBEEF, N,N,32'h0};
    // port1 write 0x20 then back-to-back read of the same address
    vecs[2]  = '{N,N,32'h0,32'h0,32'h0, Y,Y,32'h20,32'h0,32'h12345678, N,Y,N,Y,32'h20,32'h0,32'h12345678, N,N,32'h0, Y,N,32'h0};
    vecs[3]  = '{N,N,32'h0,32'h0,32'h0, Y,N,32'h10,32'h10,32'h0, N,Y,Y,N,32'h10,32'h10,32'h0, N,N,32'h0, Y,N,32'h12345678};
    // errors: misaligned, index 1024, negative
    vecs[4]  = '{Y,N,32'h100,32'h2,32'h0, N,N,32'h0,32'h0,32'h0, Y,N,N,N,32'h0,32'h0,32'h0, Y,Y,32'h0, N,N,32'h0};
    vecs[5]  = '{N,N,32'h0,32'h0,32'h0, Y,N,32'h1000,32'h0,32'h0, N,Y,N,N,32'h0,32'h0,32'h0, N,N,32'h0, Y,Y,32'h0};
    vecs[6]  = '{Y,N,32'h0,32'hFFFFFFFC,32'h0, N,N,32'h0,32'h0,32'h0, Y,N,N,N,32'h0,32'h0,32'h0, Y,Y,32'h0, N,N,32'h0};
    // last legal word (index 1023): write then read from the other port
    vecs[7]  = '{Y,Y,32'hFFC,32'h0,32'hA5A5A5A5, N,N,32'h0,32'h0,32'h0, Y,N,N,Y,32'hFFC,32'h0,32'hA5A5A5A5, Y,N,32'h0, N,N,32'h0};
    vecs[8]  = '{N,N,32'h0,32'h0,32'h0, Y,N,32'hF00,32'hFC,32'h0, N,Y,Y,N,32'hF00,32'hFC,32'h0, N,N,32'h0, Y,N,32'hA5A5A5A5};
    // contention for 4 cycles: grants 0,1,0,1
    vecs[9]  = '{Y,N,32'h100,32'h4,32'h0, Y,N,32'hFFC,32'h0,32'h0, Y,N,Y,N,32'h100,32'h4,32'h0, Y,N,32'hDEADBEEF, N,N,32'h0};
    vecs[10] = '{Y,N,32'h100,32'h4,32'h0, Y,N,32'hFFC,32'h0,32'h0, N,Y,Y,N,32'hFFC,32'h0,32'h0, N,N,32'h0, Y,N,32'hA5A5A5A5};
    vecs[11] = vecs[9];
    vecs[12] = vecs[10];
    // write with negative ea: error, no strobe
    vecs[13] = '{N,N,32'h0,32'h0,32'h0, Y,Y,32'h0,32'hFFFFFFF8,32'h11111111, N,Y,N,N,32'h0,32'h0,32'h0, N,N,32'h0, Y,Y,32'h0};
    // negative offset, legal: 0x108-8 = 0x100 (word 0x40)
    vecs[14] = '{Y,N,32'h108,32'hFFFFFFF8,32'h0, N,N,32'h0,32'h0,32'h0, Y,N,Y,N,32'h108,32'hFFFFFFF8,32'h0, Y,N,32'hCAFEF00D, N,N,32'h0};
    // contended error grant still consumes the slot and flips prio; held port1 write goes next
    vecs[15] = '{Y,N,32'h102,32'h0,32'h0, Y,Y,32'h40,32'h0,32'h77777777, Y,N,N,N,32'h0,32'h0,32'h0, Y,Y,32'h0, N,N,32'h0};
    vecs[16] = '{Y,N,32'h102,32'h0,32'h0, Y,Y,32'h40,32'h0,32'h77777777, N,Y,N,Y,32'h40,32'h0,32'h77777777, N,N,32'h0, Y,N,32'h0};
    vecs[17] = '{Y,N,32'h40,32'h0,32'h0, N,N,32'h0,32'h0,32'h0, Y,N,Y,N,32'h40,32'h0,32'h0, Y,N,32'h77777777, N,N,32'h0};
    vecs[18] = vecs[0];

    // ---- reset state, with requests present ----
    rst = 1'b1; preload = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_base = 32'h100; req0_offset = 32'h4; req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_we = 1'b1; req1_base = 32'h20;  req1_offset = 32'h0; req1_wdata = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_ren", mem_r_enabled, 1'b0);
    chk1("rst_wen", mem_w_enabled, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_rdata", rsp0_rdata, 32'h0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; preload = 1'b0;
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req0_we = vecs[i].we0; req0_base = vecs[i].b0;
      req0_offset = vecs[i].o0; req0_wdata = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_we = vecs[i].we1; req1_base = vecs[i].b1;
      req1_offset = vecs[i].o1; req1_wdata = vecs[i].d1;
      #1;
      chk1($sformatf("v%0d_ready0", i), req0_ready, vecs[i].rdy0);
      chk1($sformatf("v%0d_ready1", i), req1_ready, vecs[i].rdy1);
      chk1($sformatf("v%0d_ren", i), mem_r_enabled, vecs[i].ren);
      chk1($sformatf("v%0d_wen", i), mem_w_enabled, vecs[i].wen);
      chk($sformatf("v%0d_mem_base", i), mem_base, vecs[i].mb);
      chk($sformatf("v%0d_mem_offset", i), mem_offset, vecs[i].mo);
      chk($sformatf("v%0d_mem_wdata", i), mem_w_data, vecs[i].mwd);
      @(posedge clk);
      #1;
      chk1($sformatf("v%0d_rsp0_valid", i), rsp0_valid, vecs[i].rv0);
      chk1($sformatf("v%0d_rsp0_err", i), rsp0_err, vecs[i].re0);
      chk($sformatf("v%0d_rsp0_rdata", i), rsp0_rdata, vecs[i].rd0);
      chk1($sformatf("v%0d_rsp1_valid", i), rsp1_valid, vecs[i].rv1);
      chk1($sformatf("v%0d_rsp1_err", i), rsp1_err, vecs[i].re1);
      chk($sformatf("v%0d_rsp1_rdata", i), rsp1_rdata, vecs[i].rd1);
    end

    // ---- reset mid-operation; prio must return to PRIO_INIT ----
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_base = 32'h100; req0_offset = 32'h4;
    req1_valid = 1'b1; req1_we = 1'b0; req1_base = 32'hFFC; req1_offset = 32'h0;
    #1;
    chk1("mid_ready0", req0_ready, 1'b1);
    @(posedge clk);  // contended accept of port 0: prio moves to 1
    #1;
    chk1("mid_rsp0_valid_pre", rsp0_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("mid_rsp0_valid_drop", rsp0_valid, 1'b0);
    chk("mid_rsp0_rdata_drop", rsp0_rdata, 32'h0);
    chk1("mid_ren_quiet", mem_r_enabled, 1'b0);
    chk1("mid_ready0_quiet", req0_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("post_rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("post_rst_rsp1_valid", rsp1_valid, 1'b0);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("post_rst_prio_ready0", req0_ready, 1'b1);
    chk1("post_rst_prio_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
